imem_boot_loader: RTL and testbench
===================================

// Module: imem_boot_loader
// PURPOSE
//   Writer side of the core's instruction-memory interface. Receives a program image as a
//   byte stream (valid/ready), packs the bytes into 32-bit little-endian words and writes
//   them into instruction memory starting at word 0. Holds riscv_core in reset until the
//   whole image has been written, then releases it. Sits between the host byte source and
//   the imem write port plus the core reset input.
// PARAMETERS
//   ADDR_W  8  imem word-address width; capacity DEPTH = 2**ADDR_W words
// PORTS
//   clk          in   1       system clock, all logic on rising edge
//   rst          in   1       synchronous, active-high reset
//   in_valid     in   1       byte source has in_data valid
//   in_ready     out  1       loader accepts a byte this cycle
//   in_data      in   8       stream byte
//   reload       in   1       1-cycle pulse: restart load, re-assert core reset
//   imem_we      out  1       imem write strobe, 1-cycle pulse per word
//   imem_addr    out  ADDR_W  imem word address
//   imem_wdata   out  32      imem write data
//   core_rst     out  1       reset to riscv_core, 1 = held in reset
//   done         out  1       image loaded, core running
//   error        out  1       bad header, sticky until rst/reload
// BEHAVIOUR
//   - Frame: 4-byte LE word count N, then N*4 image bytes, LE per word (first byte -> [7:0]).
//   - Handshake: a byte transfers on a rising edge with in_valid & in_ready. in_data is
//     ignored otherwise.
//   - States:
//       S_LEN   collect N; in_ready=1
//       S_DATA  collect words; in_ready=1
//       S_RUN   in_ready=0, core_rst=0, done=1
//       S_ERR   in_ready=0, core_rst=1, error=1
//   - Reset values: state=S_LEN, byte_cnt=0, word_idx=0, in_ready=1, imem_we=0,
//     imem_addr=0, imem_wdata=0, core_rst=1, done=0, error=0.
//   - All outputs come straight from registers or from state-register decode; there is no
//     combinational path from in_valid to any output.
//   - S_LEN, on the 4th byte:
//       N==0 or N>DEPTH  -> S_ERR
//       otherwise        -> S_DATA, with word_idx=0
//   - S_DATA, on the 4th byte of a word (edge k):
//       imem_we=1, imem_addr=word_idx, imem_wdata=packed word, all valid in the cycle
//       after edge k; word_idx increments.
//   - Every other cycle imem_we=0; addr and wdata hold their last values.
//   - Last word (word_idx==N-1 at edge k): state becomes S_RUN at edge k+1, so core_rst
//     falls one cycle after the final imem_we pulse and the core never fetches an
//     unwritten word.
//   - Back-to-back bytes (in_valid held high) are accepted every cycle with no bubbles.
//   - reload in S_RUN or S_ERR -> S_LEN, core_rst=1 on the next edge, counters cleared,
//     done=0, error=0. reload in S_LEN or S_DATA is ignored.
//   - rst has priority over reload and over a byte accepted in the same cycle.
//   - rst during a load discards the partial byte/word and restarts in S_LEN.
//     Memory contents are not cleared.
//   - byte_cnt is 2 bits and wraps 3->0. N is held in 32 bits, compared against DEPTH
//     unsigned.
// STRUCTURE
//   - Shared header riscv_defs.vh: loader state encodings (S_LEN/S_DATA/S_RUN/S_ERR,
//     2 bits) and the LOADER_HDR_BYTES=4 constant.
//   - Sub-module byte_packer: 2-bit byte counter plus 32-bit LE shift/insert register,
//     pulsing word_valid on the 4th byte. It is reused for both the header and the data
//     words.
//   - FSM, word_idx counter and output registers live in imem_boot_loader.
// TESTING
//   1. Reset: hold rst 3 cycles -> core_rst=1, in_ready=1, imem_we=0, done=0, error=0.
//   2. Stream 02 00 00 00, 13 01 50 00, 93 01 30 00 (in_valid held high) ->
//      imem_we pulses with (addr 0, 0x00500113) and then (addr 1, 0x00300193).
//      core_rst falls 1 cycle after the 2nd pulse. With riscv_core attached,
//      x2=5 and x3=3 within 20 cycles.
//   3. Header 00 00 00 00 -> error=1, in_ready=0, no imem_we, core_rst stays 1.
//      Header 01 01 00 00 (N=257, ADDR_W=8) gives the same response.
//   4. in_valid toggling 1/0 each cycle during a 1-word image -> exactly 1 imem_we,
//      correct LE word, no bytes lost or duplicated.
//   5. rst asserted after 6 of 12 bytes, then the full 12-byte frame resent ->
//      only 2 imem_we pulses after the reset, data matches test 2.
//   6. reload pulse in S_RUN -> core_rst=1 and done=0 next cycle, in_ready=1.
//      A new 1-word image 37 05 00 00 writes addr 0 = 0x00000537.
//      reload together with rst -> rst behaviour only.

Source files
------------

// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   - Loader FSM state encodings (2 bits).
//   - Header length in bytes (one little-endian 32-bit word count).
//   - hdr_len_ok(): checks a word count against the imem capacity.
package imem_boot_loader_pkg;

  typedef logic [1:0] loader_state_t;

  localparam loader_state_t S_LEN  = 2'd0;
  localparam loader_state_t S_DATA = 2'd1;
  localparam loader_state_t S_RUN  = 2'd2;
  localparam loader_state_t S_ERR  = 2'd3;

  localparam int unsigned LOADER_HDR_BYTES = 4;

  // A word count is usable when it is non-zero and fits in 2**addr_w words.
  // The compare is done in 33 bits, so addr_w == 32 does not overflow.
  function automatic logic hdr_len_ok(input logic [31:0] n, input int unsigned addr_w);
    logic [32:0] depth;
    depth = 33'd1 << addr_w;
    return (n != 32'd0) && ({1'b0, n} <= depth);
  endfunction

endpackage

// File: rtl/imem_boot_loader_byte_packer.sv
// Packs a byte stream into 32-bit little-endian words.
// The first byte of a word lands in [7:0]. word_valid pulses in the same cycle as the
// 4th byte is accepted. word is valid only while word_valid is high.
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset; clears the byte counter
//   clear       synchronous restart; discards any partial word
//   byte_en     a byte is accepted this cycle
//   byte_in     accepted byte
//   word_valid  4th byte of a word accepted this cycle
//   word        assembled word: {byte_in, earlier three bytes}
module imem_boot_loader_byte_packer
  import imem_boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  localparam logic [1:0] LastByte = 2'(LOADER_HDR_BYTES - 1);

  logic [1:0]  cnt_q, cnt_d;
  // Only the first three bytes need storing; the fourth is taken straight from byte_in.
  logic [23:0] sr_q, sr_d;

  always_comb begin
    cnt_d = cnt_q;
    sr_d  = sr_q;
    if (clear) begin
      cnt_d = 2'd0;
    end else if (byte_en) begin
      cnt_d = cnt_q + 2'd1;  // 2-bit counter wraps 3 -> 0
      sr_d  = {byte_in, sr_q[23:8]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 2'd0;
      sr_q  <= 24'd0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end

  assign word_valid = byte_en && !clear && (cnt_q == LastByte);
  assign word       = {byte_in, sr_q};

endmodule

// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader.
// Receives a program image as a byte stream (4-byte LE word count N, then N LE words),
// writes the words into imem from word 0 upward and holds the core in reset until the
// last word is written. A bad word count (0 or larger than imem) parks the loader in an
// error state. reload restarts the load from S_RUN or S_ERR.
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   in_valid    byte source has in_data valid
//   in_ready    loader accepts a byte this cycle
//   in_data     stream byte
//   reload      1-cycle pulse: restart load, re-assert core reset (S_RUN/S_ERR only)
//   imem_we     imem write strobe, one pulse per word
//   imem_addr   imem word address
//   imem_wdata  imem write data
//   core_rst    core reset, 1 = held in reset
//   done        image loaded, core running
//   error       bad header, sticky until rst/reload
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              error
);

  loader_state_t     state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [ADDR_W-1:0] word_idx_q, word_idx_d;
  logic [31:0]       n_q, n_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic        accept;
  logic        reload_ok;
  logic        word_valid;
  logic [31:0] word;
  logic        last_word;

  // in_ready is a register, so accept never feeds an output combinationally.
  assign accept    = in_valid && in_ready_q;
  assign reload_ok = reload && ((state_q == S_RUN) || (state_q == S_ERR));
  assign last_word = (32'(word_idx_q) == (n_q - 32'd1));

  // One packer serves both the header word and the image words.
  imem_boot_loader_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (reload_ok),
    .byte_en    (accept),
    .byte_in    (in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_d    = state_q;
    in_ready_d = in_ready_q;
    word_idx_d = word_idx_q;
    n_d        = n_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    case (state_q)
      S_LEN: begin
        if (word_valid) begin
          n_d        = word;
          word_idx_d = '0;
          if (hdr_len_ok(word, ADDR_W)) begin
            state_d = S_DATA;
          end else begin
            state_d    = S_ERR;
            in_ready_d = 1'b0;
          end
        end
      end
      S_DATA: begin
        if (!in_ready_q) begin
          // Last word went out on the previous edge; release the core one cycle
          // after its write pulse so no fetch can see an unwritten word.
          state_d = S_RUN;
        end else if (word_valid) begin
          we_d       = 1'b1;
          addr_d     = word_idx_q;
          wdata_d    = word;
          word_idx_d = word_idx_q + 1'b1;
          if (last_word) begin
            in_ready_d = 1'b0;
          end
        end
      end
      S_RUN, S_ERR: begin
        if (reload) begin
          state_d    = S_LEN;
          in_ready_d = 1'b1;
          word_idx_d = '0;
          n_d        = 32'd0;
        end
      end
      default: begin
        state_d    = S_LEN;
        in_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_LEN;
      in_ready_q <= 1'b1;
      word_idx_q <= '0;
      n_q        <= 32'd0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      word_idx_q <= word_idx_d;
      n_q        <= n_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_rst   = (state_q != S_RUN);
  assign done       = (state_q == S_RUN);
  assign error      = (state_q == S_ERR);

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        reload;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst;
  logic        done;
  logic        error;

  imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .reload     (reload),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
    logic        last;
  } wr_t;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  wr_t         exp_q[$];
  logic [7:0]  frame[$];
  logic [31:0] mem[DEPTH];
  bit          last_pend = 1'b0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: pops the scoreboard on every write strobe.
  always @(posedge clk) begin
    wr_t e;
    #1;
    if (last_pend) begin
      check("core_rst released after last write", {31'd0, core_rst}, 32'd0);
      check("done after last write", {31'd0, done}, 32'd1);
      last_pend = 1'b0;
    end
    if (imem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected imem_we", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("imem_addr", {24'd0, imem_addr}, {24'd0, e.addr});
        check("imem_wdata", imem_wdata, e.data);
        check("core_rst held during write", {31'd0, core_rst}, 32'd1);
        if (e.last) last_pend = 1'b1;
      end
      mem[imem_addr] = imem_wdata;
    end
  end

  task automatic add_word(input logic [31:0] w);
    frame.push_back(w[7:0]);
    frame.push_back(w[15:8]);
    frame.push_back(w[23:16]);
    frame.push_back(w[31:24]);
  endtask

  // Reference model: parse the frame and queue the writes it should produce.
  task automatic model_frame(output bit exp_err);
    logic [31:0] n;
    n = {frame[3], frame[2], frame[1], frame[0]};
    exp_err = (n == 32'd0) || (n > DEPTH);
    if (!exp_err) begin
      for (int i = 0; i < int'(n); i++) begin
        wr_t e;
        e.addr = 8'(i);
        e.data = {frame[4 + 4*i + 3], frame[4 + 4*i + 2], frame[4 + 4*i + 1], frame[4 + 4*i]};
        e.last = (i == int'(n) - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  // gap_mode: 0 back-to-back, 1 toggle valid, 2 random idle cycles.
  task automatic send_frame(input int gap_mode, input int max_bytes);
    int lim;
    lim = (max_bytes < 0) ? frame.size() : max_bytes;
    for (int i = 0; i < lim; i++) begin
      int gaps;
      int b;
      gaps = (gap_mode == 1) ? ((i > 0) ? 1 : 0) :
             (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
      repeat (gaps) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = frame[i];
      b = 0;
      while (!in_ready && b < 50) begin
        @(negedge clk);
        b++;
      end
      if (b >= 50) begin
        check("in_ready timeout", 32'd0, 32'd1);
        break;
      end
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic wait_result(input bit exp_err);
    int b;
    b = 0;
    while (!(done || error) && b < 40) begin
      @(negedge clk);
      b++;
    end
    check("done outcome", {31'd0, done}, {31'd0, !exp_err});
    check("error outcome", {31'd0, error}, {31'd0, exp_err});
    check("in_ready after load", {31'd0, in_ready}, 32'd0);
    check("core_rst after load", {31'd0, core_rst}, {31'd0, exp_err});
    check("writes outstanding", exp_q.size(), 32'd0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " core_rst"}, {31'd0, core_rst}, 32'd1);
    check({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, " done"}, {31'd0, done}, 32'd0);
    check({tag, " error"}, {31'd0, error}, 32'd0);
    check({tag, " imem_we"}, {31'd0, imem_we}, 32'd0);
  endtask

  task automatic do_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check_idle("reload");
    frame.delete();
  endtask

  task automatic run_frame(input int gap_mode);
    bit exp_err;
    model_frame(exp_err);
    send_frame(gap_mode, -1);
    wait_result(exp_err);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bit e;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'd0;
    reload   = 1'b0;

    // Reset
    repeat (3) @(negedge clk);
    check_idle("reset");
    check("reset imem_addr", {24'd0, imem_addr}, 32'd0);
    check("reset imem_wdata", imem_wdata, 32'd0);
    rst = 1'b0;

    // Two-word program, back-to-back bytes
    add_word(32'd2); add_word(32'h00500113); add_word(32'h00300193);
    run_frame(0);
    check("mem[0] program", mem[0], 32'h00500113);
    check("mem[1] program", mem[1], 32'h00300193);

    // Bad headers: N = 0 and N = DEPTH + 1
    do_reload();
    add_word(32'd0);
    run_frame(0);
    do_reload();
    add_word(32'd257);
    run_frame(0);

    // Toggling valid, one-word image
    do_reload();
    add_word(32'd1); add_word(32'hdeadbeef);
    run_frame(1);
    check("mem[0] toggled", mem[0], 32'hdeadbeef);

    // rst after 6 bytes, then full resend
    do_reload();
    add_word(32'd2); add_word(32'h00500113); add_word(32'h00300193);
    send_frame(0, 6);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("mid-load rst");
    mem[0] = 32'd0;
    mem[1] = 32'd0;
    run_frame(0);
    check("mem[0] after restart", mem[0], 32'h00500113);
    check("mem[1] after restart", mem[1], 32'h00300193);

    // reload in S_RUN, new image
    do_reload();
    add_word(32'd1); add_word(32'h00000537);
    run_frame(0);
    check("mem[0] reloaded", mem[0], 32'h00000537);

    // reload together with rst
    @(negedge clk);
    rst    = 1'b1;
    reload = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    reload = 1'b0;
    check_idle("rst+reload");
    frame.delete();

    // Randomized frames
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 4) == 0) begin
        add_word(($urandom_range(0, 1) == 1) ? 32'd0 : 32'd257 + $urandom_range(0, 100000));
      end else begin
        int n;
        n = int'($urandom_range(1, 6));
        add_word(32'(n));
        for (int w = 0; w < n; w++) add_word($urandom);
      end
      run_frame(2);
      do_reload();
    end

    // Full-capacity image
    add_word(DEPTH);
    for (int w = 0; w < int'(DEPTH); w++) add_word($urandom);
    model_frame(e);
    send_frame(2, -1);
    wait_result(e);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
